// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode operands, addresses and controls, gates side effects, counts bubbles.
// Latency: 1 cycle from id_* to ex_*; no combinational input-to-output path.
// Backpressure: stall holds every registered field; flush overrides stall and loads a bubble.
module id_ex_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_pc4,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic [2:0]       id_alu_ctrl,
  input  logic [1:0]       id_result_src,
  input  logic             id_reg_write,
  input  logic             id_mem_write,
  input  logic             id_mem_read,
  input  logic             id_alu_src,
  input  logic             id_branch,
  input  logic             id_jump,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_pc4,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic [2:0]       ex_alu_ctrl,
  output logic [1:0]       ex_result_src,
  output logic             ex_reg_write,
  output logic             ex_mem_write,
  output logic             ex_mem_read,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Operand and address payload; loaded verbatim even for invalid slots.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
  } data_t;

  // Control bundle; side-effecting bits are qualified before capture.
  typedef struct packed {
    logic       valid;
    logic [2:0] alu_ctrl;
    logic [1:0] result_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  data_t            data_q, data_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q;
  logic             load_bubble;
  logic             cnt_en;

  // Assemble the incoming payload and apply validity / x0 gating to the controls.
  always_comb begin
    data_d          = '0;
    data_d.pc       = id_pc;
    data_d.pc4      = id_pc4;
    data_d.rs1_data = id_rs1_data;
    data_d.rs2_data = id_rs2_data;
    data_d.imm      = id_imm;
    data_d.rs1      = id_rs1;
    data_d.rs2      = id_rs2;
    data_d.rd       = id_rd;
    data_d.funct3   = id_funct3;
    data_d.funct7b5 = id_funct7b5;

    ctrl_d            = '0;
    ctrl_d.valid      = id_valid;
    ctrl_d.alu_ctrl   = id_alu_ctrl;
    ctrl_d.result_src = id_result_src;
    ctrl_d.alu_src    = id_alu_src;
    // Writes to x0 are architecturally discarded, so never let them reach writeback.
    ctrl_d.reg_write  = id_reg_write & id_valid & (id_rd != 5'd0);
    ctrl_d.mem_write  = id_mem_write & id_valid;
    ctrl_d.mem_read   = id_mem_read  & id_valid;
    ctrl_d.branch     = id_branch    & id_valid;
    ctrl_d.jump       = id_jump      & id_valid;
  end

  // A bubble is latched by a flush or by a normal load of an empty decode slot.
  always_comb begin
    load_bubble = flush | (~stall & ~id_valid);
    cnt_en      = load_bubble & (cnt_q != CNT_MAX);
  end

  // Pipeline payload register: flush beats stall, stall beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (flush) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (!stall) begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  // Saturating debug count of latched bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Output fan-out straight from the registers.
  always_comb begin
    ex_valid      = ctrl_q.valid;
    ex_pc         = data_q.pc;
    ex_pc4        = data_q.pc4;
    ex_rs1_data   = data_q.rs1_data;
    ex_rs2_data   = data_q.rs2_data;
    ex_imm        = data_q.imm;
    ex_rs1        = data_q.rs1;
    ex_rs2        = data_q.rs2;
    ex_rd         = data_q.rd;
    ex_funct3     = data_q.funct3;
    ex_funct7b5   = data_q.funct7b5;
    ex_alu_ctrl   = ctrl_q.alu_ctrl;
    ex_result_src = ctrl_q.result_src;
    ex_reg_write  = ctrl_q.reg_write;
    ex_mem_write  = ctrl_q.mem_write;
    ex_mem_read   = ctrl_q.mem_read;
    ex_alu_src    = ctrl_q.alu_src;
    ex_branch     = ctrl_q.branch;
    ex_jump       = ctrl_q.jump;
    bubble_cnt    = cnt_q;
  end

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int VW    = 191;

  logic clk = 1'b0;
  logic rst_n;
  logic stall, flush, id_valid;
  logic [XLEN-1:0] id_pc, id_pc4, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3, id_alu_ctrl;
  logic id_funct7b5;
  logic [1:0] id_result_src;
  logic id_reg_write, id_mem_write, id_mem_read, id_alu_src, id_branch, id_jump;

  logic ex_valid;
  logic [XLEN-1:0] ex_pc, ex_pc4, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3, ex_alu_ctrl;
  logic ex_funct7b5;
  logic [1:0] ex_result_src;
  logic ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_src, ex_branch, ex_jump;
  logic [CNT_W-1:0] bubble_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic check_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_pc4(id_pc4), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_alu_ctrl(id_alu_ctrl),
    .id_result_src(id_result_src), .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
    .id_mem_read(id_mem_read), .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_result_src(ex_result_src), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .bubble_cnt(bubble_cnt)
  );

  // Whole execute-stage view as one vector, in a fixed field order.
  function automatic logic [VW-1:0] dut_vec();
    return {ex_valid, ex_pc, ex_pc4, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
            ex_funct3, ex_funct7b5, ex_alu_ctrl, ex_result_src, ex_reg_write, ex_mem_write,
            ex_mem_read, ex_alu_src, ex_branch, ex_jump};
  endfunction

  // Reference model: what the execute stage should see, from the update rules.
  logic [VW-1:0]    exp_v;
  int               exp_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_v   <= '0;
      exp_cnt <= 0;
    end else if (flush) begin
      exp_v   <= '0;
      exp_cnt <= (exp_cnt + 1 > 15) ? 15 : exp_cnt + 1;
    end else if (!stall) begin
      exp_v <= {id_valid, id_pc, id_pc4, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
                id_funct3, id_funct7b5, id_alu_ctrl, id_result_src,
                id_reg_write && id_valid && id_rd != 0, id_mem_write && id_valid,
                id_mem_read && id_valid, id_alu_src, id_branch && id_valid, id_jump && id_valid};
      if (!id_valid) exp_cnt <= (exp_cnt + 1 > 15) ? 15 : exp_cnt + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      n_chk++;
      if (dut_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL model_ex t=%0t got=%h want=%h", $time, dut_vec(), exp_v);
      end
      n_chk++;
      if (int'(bubble_cnt) != exp_cnt) begin
        n_fail++;
        $display("FAIL model_cnt t=%0t got=%0d want=%0d", $time, bubble_cnt, exp_cnt);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                           input logic [31:0] r2d, input logic [31:0] imm, input logic [4:0] rd,
                           input logic [5:0] ctl);
    id_valid = v; id_pc = pc; id_pc4 = pc + 4; id_rs1_data = r1d; id_rs2_data = r2d;
    id_imm = imm; id_rs1 = rd + 5'd1; id_rs2 = rd + 5'd2; id_rd = rd;
    id_funct3 = pc[4:2]; id_funct7b5 = pc[5]; id_alu_ctrl = r1d[2:0]; id_result_src = r2d[1:0];
    {id_reg_write, id_mem_write, id_mem_read, id_alu_src, id_branch, id_jump} = ctl;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_instr(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 6'b0);
    repeat (2) step();
    // Load test vector presented before reset release so no bubble is counted.
    set_instr(1'b1, 32'h0000_0100, 32'h0000_1234, 32'h0000_00AA, 32'hFFFF_FFF0, 5'd5, 6'b100000);
    chk("reset_valid", 64'(ex_valid), 64'd0);
    chk("reset_cnt", 64'(bubble_cnt), 64'd0);
    rst_n = 1'b1;
    check_en = 1'b1;
    step();
    chk("load_reg_write", 64'(ex_reg_write), 64'd1);
    chk("load_rd", 64'(ex_rd), 64'd5);
    chk("load_rs1_data", 64'(ex_rs1_data), 64'h0000_1234);
    chk("load_imm", 64'(ex_imm), 64'hFFFF_FFF0);
    chk("load_valid", 64'(ex_valid), 64'd1);

    // x0 destination must not write back.
    set_instr(1'b1, 32'h0000_0104, 32'h1, 32'h2, 32'h3, 5'd0, 6'b100000);
    step();
    chk("x0_reg_write", 64'(ex_reg_write), 64'd0);
    chk("x0_valid", 64'(ex_valid), 64'd1);

    // Instruction A, then a 3-cycle stall with changing inputs.
    set_instr(1'b1, 32'h0000_0A00, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0000_0010, 5'd9, 6'b111111);
    step();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      set_instr(1'b1, 32'h0000_2000 + 32'(i * 4), 32'h5555_0000 + 32'(i), 32'h7, 32'h8,
                5'(i + 20), 6'b110000);
      step();
      chk("stall_pc", 64'(ex_pc), 64'h0000_0A00);
      chk("stall_rs1_data", 64'(ex_rs1_data), 64'hDEAD_BEEF);
      chk("stall_mem_write", 64'(ex_mem_write), 64'd1);
    end
    // Flush with stall: bubble wins.
    flush = 1'b1;
    step();
    chk("flush_valid", 64'(ex_valid), 64'd0);
    chk("flush_ctrl", 64'({ex_reg_write, ex_mem_write, ex_mem_read, ex_branch, ex_jump}), 64'd0);
    chk("flush_pc", 64'(ex_pc), 64'd0);
    chk("flush_cnt", 64'(bubble_cnt), 64'd1);

    // Invalid slot: controls gated, data still loads, counter bumps.
    stall = 1'b0; flush = 1'b0;
    set_instr(1'b0, 32'h0000_0300, 32'h0000_4444, 32'h1, 32'h2, 5'd7, 6'b111111);
    step();
    chk("inv_mem_write", 64'(ex_mem_write), 64'd0);
    chk("inv_reg_write", 64'(ex_reg_write), 64'd0);
    chk("inv_rs1_data", 64'(ex_rs1_data), 64'h0000_4444);
    chk("inv_cnt", 64'(bubble_cnt), 64'd2);

    // A short mix of valid/invalid loads and stalls checked by the model.
    for (int i = 0; i < 12; i++) begin
      stall = (i % 4 == 3);
      set_instr(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)));
      step();
    end

    // Saturation: 20 flushes pin the counter at 15.
    stall = 1'b0; flush = 1'b1;
    repeat (20) step();
    chk("sat_cnt", 64'(bubble_cnt), 64'd15);
    step();
    chk("sat_hold", 64'(bubble_cnt), 64'd15);
    flush = 1'b0;

    // Asynchronous reset mid-cycle with nonzero state.
    set_instr(1'b1, 32'h0000_0C00, 32'h1111_1111, 32'h2222_2222, 32'h3, 5'd3, 6'b101010);
    step();
    chk("pre_rst_valid", 64'(ex_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(ex_valid), 64'd0);
    chk("async_rst_pc", 64'(ex_pc), 64'd0);
    chk("async_rst_rs1", 64'(ex_rs1_data), 64'd0);
    chk("async_rst_cnt", 64'(bubble_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_pc", 64'(ex_pc), 64'h0000_0C00);
    step();

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register for the five-stage RISC-V core. It captures the register-file read operands (`r_data1`/`r_data2`), the decoded immediate, the PC values, the register addresses and the control bundle from the decode stage on each rising clock edge, and presents them to the execute stage. It supports a stall (hold) and a flush (bubble insert), and tracks validity per slot. It gates architectural side effects (register write, memory write) on validity and `rd != x0`. A saturating counter records inserted bubbles for debug.

## Interface
- `XLEN`, 32, datapath width.
- `CNT_W`, 16, width of the bubble counter.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold all registered contents this cycle.
- `flush`  in  1  load a bubble this cycle.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_pc`, `id_pc4`  in  XLEN each  instruction PC and PC+4.
- `id_rs1_data`, `id_rs2_data`  in  XLEN each  register-file read data.
- `id_imm`  in  XLEN  sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register addresses.
- `id_funct3`  in  3  ALU/branch/memory subfunction.
- `id_funct7b5`  in  1  funct7 bit 5.
- `id_alu_ctrl`  in  3  ALU operation.
- `id_result_src`  in  2  writeback select.
- `id_reg_write`, `id_mem_write`, `id_mem_read`, `id_alu_src`, `id_branch`, `id_jump`  in  1 each  decoded controls.
- `ex_*`  out  same widths  registered copy of every `id_*` input above, including `ex_valid`.
- `bubble_cnt`  out  CNT_W  saturating count of bubbles latched.

## Operation
- Update priority on each rising edge: reset, then flush, then stall, then normal load.
- **Reset** (`rst_n`=0, asynchronous): every `ex_*` output is 0, including `ex_valid`, all controls and all data fields. `bubble_cnt` is 0. The register stays in this state until the first rising edge after `rst_n` rises.
- **Flush:** loads a bubble.
  - `ex_valid`, all control outputs and all data/address fields become 0.
  - Flush overrides a simultaneous stall.
- **Stall** (without flush): all `ex_*` outputs and `bubble_cnt` hold their values.
- **Normal load:** every `ex_*` output takes its `id_*` value, with these gated exceptions:
  - `ex_reg_write` = `id_reg_write & id_valid & (id_rd != 0)`.
  - `ex_mem_write` = `id_mem_write & id_valid`.
  - `ex_mem_read`, `ex_branch` and `ex_jump` are each ANDed with `id_valid`.
  - `ex_valid` = `id_valid`.
- A normal load with `id_valid`=0 is treated as a bubble: controls are zero per the gating above. Data fields still load the `id_*` values; the execute stage must not rely on them.
- **Bubble counter:**
  - Increments by 1 on every edge that latches a bubble: a flush, or a normal load with `id_valid`=0.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - Does not change on stall edges.
- No combinational path runs from any input to any output.

## Timing
- Latency is 1 cycle: values present on `id_*` before rising edge N appear on `ex_*` after edge N.
- The register file writes on the falling edge and drives read data combinationally. `id_rs1_data`/`id_rs2_data` must therefore be settled before the next rising edge. A writeback to register X in the first half-cycle is visible in the captured operand for a read of X in the same cycle.
- Reset assertion takes effect immediately, mid-cycle and mid-stall. Deassertion is only sampled at rising edges.
- Stall held for K cycles keeps `ex_*` constant for K edges. Normal loading resumes on the first edge with `stall`=0.
- Flush and stall asserted together for one cycle: a bubble is latched and `bubble_cnt` increments.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle with nonzero state → all `ex_*` and `bubble_cnt` read 0 immediately, before any clock edge.
- **Load:** `id_valid`=1, `id_rd`=5, `id_reg_write`=1, `id_rs1_data`=0x0000_1234, `id_imm`=0xFFFF_FFF0 → one edge later `ex_reg_write`=1, `ex_rd`=5, `ex_rs1_data`=0x0000_1234, `ex_imm`=0xFFFF_FFF0, `ex_valid`=1.
- **x0 suppression:** `id_rd`=0, `id_reg_write`=1, `id_valid`=1 → `ex_reg_write`=0, `ex_valid`=1.
- **Stall then flush:**
  - Load instruction A, then hold `stall`=1 for 3 cycles while changing the `id_*` inputs → `ex_*` stays equal to A's values for 3 edges.
  - Then assert `stall`=1 and `flush`=1 together → all controls 0, `ex_valid`=0, `bubble_cnt`=1.
- **Invalid slot:** `id_valid`=0 with `id_mem_write`=1 → `ex_mem_write`=0 and `bubble_cnt` increments by 1.
- **Saturation:** with CNT_W=4, apply 20 consecutive flushes → `bubble_cnt` reaches 15 and stays at 15.
